// File: rtl/pattern_match_ctrl_if.sv
// Bundle of config, command, serial-input and status signals for pattern_match_ctrl.
// The master side is the test/control logic plus the bit source; the slave side is the controller.
interface pattern_match_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Config handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready;
  // cfg_pattern/cfg_len are sampled only then, and the master holds them stable until it does.
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               a_valid;
  logic               a;
  logic               busy;
  logic               detected;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               timeout;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, start, stop, a_valid, a,
    input  cfg_ready, cfg_err, busy, detected, match_cnt, done, timeout
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, start, stop, a_valid, a,
    output cfg_ready, cfg_err, busy, detected, match_cnt, done, timeout
  );
endinterface

// File: rtl/pattern_match_ctrl.sv
// Run-time programmable serial pattern detector with overlapping matches and a saturating hit count.
// Optional idle timeout in ARMED is compiled in with `define PMC_TIMEOUT_EN.
module pattern_match_ctrl #(
  parameter int MAX_LEN   = 8,
  parameter int CNT_W     = 8
`ifdef PMC_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pattern_match_ctrl_if.slave  bus,
  output logic [1:0]           state_o
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic               cfg_loaded_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               detected_q;
  logic               cfg_err_q;
  logic               done_q;
  logic               timeout_q;

  logic               cfg_fire;
  logic               cfg_legal;
  logic [MAX_LEN-1:0] hist_d;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               fill_full;
  logic [LEN_W-1:0]   fill_d;
  logic               hit;
  logic               tmo_expire;

  always_comb begin
    cfg_fire  = bus.cfg_valid && (state_q == ST_IDLE);
    cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
    hist_d    = {hist_q[MAX_LEN-2:0], bus.a};
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    // fill_inc is one bit wider so fill+1 cannot wrap when len == MAX_LEN
    fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
    fill_full = (fill_inc >= {1'b0, len_q});
    fill_d    = fill_full ? len_q : fill_inc[LEN_W-1:0];
    hit       = (state_q == ST_ARMED) && bus.a_valid && fill_full &&
                (((hist_d ^ pattern_q) & len_mask) == '0);
  end

`ifdef PMC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tmo_d;

  always_comb begin
    tmo_d      = hit ? '0 : (tmo_q + TIMEOUT_W'(1));
    tmo_expire = &tmo_d;
  end

  // Held at zero outside ARMED so every arm starts a fresh idle window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q != ST_ARMED) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pattern_q    <= '0;
      hist_q       <= '0;
      len_q        <= '0;
      fill_q       <= '0;
      cfg_loaded_q <= 1'b0;
      cnt_q        <= '0;
      detected_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      detected_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_fire) begin
            if (cfg_legal) begin
              pattern_q    <= bus.cfg_pattern;
              len_q        <= bus.cfg_len;
              cfg_loaded_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          // A legal config in the same cycle counts as loaded for this start
          if (bus.start && (cfg_loaded_q || (cfg_fire && cfg_legal))) begin
            state_q <= ST_ARMED;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
          end
        end
        ST_ARMED: begin
          if (bus.a_valid) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
          end
          if (hit) begin
            detected_q <= 1'b1;
            if (!(&cnt_q)) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          if (bus.stop) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (tmo_expire) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_ARMED);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.detected  = detected_q;
  assign bus.match_cnt = cnt_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign state_o       = state_q;

endmodule
